// File: rtl/uart_core_param.sv
// Parametrised UART transceiver: TX serialiser + RX deserialiser on one clock.
// Ports: clk/rst (sync, active-high); tx_start/tx_data in, tx_busy/tx_done/tx_out out;
//        rx_in, loopback in; rx_data/rx_done/rx_parity_err/rx_frame_err out.
module uart_core_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_out,
    input  logic              rx_in,
    input  logic              loopback,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_parity_err,
    output logic              rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // ---------------- TX ----------------
    state_t              r_tx_state, w_tx_state_n;
    logic [CW-1:0]       r_tx_cnt,   w_tx_cnt_n;
    logic [BW-1:0]       r_tx_bit,   w_tx_bit_n;
    logic [DATA_W-1:0]   r_tx_shift, w_tx_shift_n;
    logic                r_tx_par,   w_tx_par_n;
    logic                r_tx_out,   w_tx_out_n;
    logic                r_tx_busy,  w_tx_busy_n;
    logic                r_tx_done,  w_tx_done_n;
    logic                w_tx_tick;
    logic                w_tx_par_calc;

    assign w_tx_par_calc = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
    assign w_tx_tick     = (r_tx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_par   <= w_tx_par_n;
            r_tx_out   <= w_tx_out_n;
            r_tx_busy  <= w_tx_busy_n;
            r_tx_done  <= w_tx_done_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_par_n   = r_tx_par;
        w_tx_out_n   = r_tx_out;
        w_tx_busy_n  = r_tx_busy;
        w_tx_done_n  = 1'b0;
        unique case (r_tx_state)
            S_IDLE: begin
                w_tx_out_n  = 1'b1;
                w_tx_busy_n = 1'b0;
                w_tx_cnt_n  = '0;
                if (tx_start) begin
                    w_tx_state_n = S_START;
                    w_tx_shift_n = tx_data;
                    w_tx_par_n   = w_tx_par_calc;
                    w_tx_out_n   = 1'b0;
                    w_tx_busy_n  = 1'b1;
                    w_tx_bit_n   = '0;
                end
            end
            S_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = S_DATA;
                    w_tx_bit_n   = '0;
                    w_tx_out_n   = r_tx_shift[0];
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == BIT_LAST) begin
                        w_tx_bit_n = '0;
                        if (PARITY != 0) begin
                            w_tx_state_n = S_PARITY;
                            w_tx_out_n   = r_tx_par;
                        end else begin
                            w_tx_state_n = S_STOP;
                            w_tx_out_n   = 1'b1;
                        end
                    end else begin
                        // Next data bit is shift[1] before the shift lands.
                        w_tx_bit_n   = r_tx_bit + 1'b1;
                        w_tx_shift_n = r_tx_shift >> 1;
                        w_tx_out_n   = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = S_STOP;
                    w_tx_out_n   = 1'b1;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == STOP_LAST) begin
                        w_tx_state_n = S_IDLE;
                        w_tx_done_n  = 1'b1;
                        w_tx_busy_n  = 1'b0;
                        w_tx_out_n   = 1'b1;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_state_n = S_IDLE;
            end
        endcase
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

    // ---------------- RX ----------------
    logic r_sync1, r_sync2, r_rx_prev;
    logic w_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= loopback ? r_tx_out : rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;

    state_t              r_rx_state, w_rx_state_n;
    logic [CW-1:0]       r_rx_cnt,   w_rx_cnt_n;
    logic [BW-1:0]       r_rx_bit,   w_rx_bit_n;
    logic [DATA_W-1:0]   r_rx_shift, w_rx_shift_n;
    logic                r_rx_par,   w_rx_par_n;
    logic [DATA_W-1:0]   r_rx_data,  w_rx_data_n;
    logic                r_rx_perr,  w_rx_perr_n;
    logic                r_rx_ferr,  w_rx_ferr_n;
    logic                r_rx_done,  w_rx_done_n;
    logic                w_rx_tick;
    logic                w_rx_perr_calc;

    assign w_rx_tick = (r_rx_cnt == CNT_LAST);
    assign w_rx_perr_calc = (PARITY == 0) ? 1'b0 :
                            (PARITY == 1) ? ~(^r_rx_shift ^ r_rx_par) :
                                            (^r_rx_shift ^ r_rx_par);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_par   <= w_rx_par_n;
            r_rx_data  <= w_rx_data_n;
            r_rx_perr  <= w_rx_perr_n;
            r_rx_ferr  <= w_rx_ferr_n;
            r_rx_done  <= w_rx_done_n;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_par_n   = r_rx_par;
        w_rx_data_n  = r_rx_data;
        w_rx_perr_n  = r_rx_perr;
        w_rx_ferr_n  = r_rx_ferr;
        w_rx_done_n  = 1'b0;
        unique case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_n = '0;
                if (r_rx_prev && !w_rx_s) begin
                    w_rx_state_n = S_START;
                end
            end
            S_START: begin
                // Half a bit in, re-check the line to reject glitches.
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = '0;
                    w_rx_state_n = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_rx_tick) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {w_rx_s, r_rx_shift[DATA_W-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
                        w_rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_rx_tick) begin
                    w_rx_cnt_n   = '0;
                    w_rx_par_n   = w_rx_s;
                    w_rx_state_n = S_STOP;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_rx_tick) begin
                    w_rx_cnt_n   = '0;
                    w_rx_data_n  = r_rx_shift;
                    w_rx_perr_n  = w_rx_perr_calc;
                    w_rx_ferr_n  = ~w_rx_s;
                    w_rx_done_n  = 1'b1;
                    w_rx_state_n = S_IDLE;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: begin
                w_rx_state_n = S_IDLE;
            end
        endcase
    end

    assign rx_data       = r_rx_data;
    assign rx_done       = r_rx_done;
    assign rx_parity_err = r_rx_perr;
    assign rx_frame_err  = r_rx_ferr;

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised UART transceiver: one TX serialiser and one RX deserialiser sharing one clock.
- Generalises the fixed 8N1 loopback UART top with:
  - configurable data width, bit period, parity and stop-bit count;
  - RX parity and framing error flags;
  - a runtime loopback select.
- Sits between the byte-level producer/consumer logic and the external serial pins.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥4.
- DATA_W, 8, data bits per frame; legal range 5–9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks only the first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- tx_start  in  1  request to send tx_data; sampled only in TX IDLE.
- tx_data  in  DATA_W  word to transmit; captured on an accepted tx_start.
- tx_busy  out  1  high while a frame is being sent.
- tx_done  out  1  one-cycle pulse at end of frame.
- tx_out  out  1  serial line out; idles high.
- rx_in  in  1  external serial line in.
- loopback  in  1  1 = RX listens to tx_out internally; 0 = RX listens to rx_in.
- rx_data  out  DATA_W  last received word; holds until the next rx_done.
- rx_done  out  1  one-cycle pulse when a frame is received.
- rx_parity_err  out  1  parity result for the frame flagged by rx_done.
- rx_frame_err  out  1  stop-bit result for the frame flagged by rx_done.

Behaviour:
- Reset (rst high at a clock edge):
  - tx_out=1; tx_busy=0, tx_done=0, rx_done=0.
  - rx_data=0, rx_parity_err=0, rx_frame_err=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately, with no done pulse.
- Frame format: start(0), DATA_W bits LSB first, optional parity bit, STOP_BITS stop bits(1).
  - F = 1 + DATA_W + (PARITY≠0) + STOP_BITS.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - tx_start high at edge E0 while IDLE: tx_data is latched, tx_out=0 and tx_busy=1 from E0.
  - Bit k drives tx_out during cycles [E0 + k·CPB, E0 + (k+1)·CPB − 1].
  - At edge E0 + F·CPB: tx_done=1 for one cycle, tx_busy=0, tx_out=1, state IDLE.
  - tx_start while busy is ignored (no queueing).
  - tx_start in the tx_done cycle is accepted, giving back-to-back frames with no idle gap.
  - Parity bit: odd makes the 1-count over data+parity odd; even makes it even.
- RX input path:
  - Mux (loopback ? tx_out : rx_in) feeds a 2-flop synchroniser; all RX logic uses the synchronised value.
  - Loopback may only be changed while both FSMs are IDLE.
- RX FSM states: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition enters START.
  - START: wait CPB/2 cycles, then sample.
    - Sample high: false start, return to IDLE with no pulse and no flags.
    - Sample low: continue to DATA.
  - Each later bit is sampled exactly CPB cycles after the previous sample (mid-bit).
  - Data bits shift in LSB first.
  - STOP: sample the first stop bit. In the same cycle as the sample, update rx_data, rx_parity_err and rx_frame_err (frame_err = stop sample is 0), and assert rx_done for one cycle.
  - RX then returns to IDLE and re-arms on the next falling edge.
  - A low stop bit flags frame_err; the data is still delivered.
- Loopback timing: rx_done is asserted within E0 + (F_rx − 0.5)·CPB + [2..4] cycles, where F_rx = F − STOP_BITS + 1.
- Flag lifetime: rx_parity_err and rx_frame_err hold their values until the next rx_done.
- Bit-time counters are sized clog2(CLKS_PER_BIT) and wrap to 0 at CPB−1.

Test Plan:
- Default params, loopback=1; send 0x00, 0x5E, 0xA3, 0xFF, 0xC7 each after tx_done:
  - rx_data matches each word; both error flags 0.
  - tx_done at exactly E0 + 160 cycles.
  - rx_done precedes tx_done.
- DATA_W=7, PARITY=2, STOP_BITS=2, CPB=8:
  - tx_data=0x55 gives the tx_out bit sequence 0,1,0,1,0,1,0,1,0,1,1 (start, data LSB first, parity 0, two stops), each bit held 8 cycles.
  - Loopback yields rx_data=0x55, parity_err=0.
- loopback=0, PARITY=1, bench drives rx_in with 0x3C and a wrong parity bit → rx_done with rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- loopback=0, bench drives 0xA5 with stop bit 0 → rx_frame_err=1, rx_data=0xA5. Then a 3-cycle low glitch on rx_in → no rx_done (false start).
- tx_start pulsed at E0 and again at E0+20 with tx_data changed → only the first word is sent. tx_start held high through tx_done → second frame starts on the next cycle with no idle gap.
- rst asserted at E0+50 mid-frame → next cycle tx_out=1, tx_busy=0, no tx_done or rx_done. A fresh send of 0x81 completes correctly.
